// File: rtl/miriscv_hazard_pkg.sv
// Shared types and constants for the miriscv decode hazard/forwarding unit.
package miriscv_hazard_pkg;

  // Table entries store rd at a fixed width; narrower GPR addresses are zero-extended.
  localparam int HZ_RD_MAX_WIDTH = 8;

  // Operand source code for "read from the register file".
  localparam int HZ_SRC_GPR = 0;

  typedef struct packed {
    logic                       valid;
    logic [HZ_RD_MAX_WIDTH-1:0] rd;
    logic                       we;
    logic                       load;
  } hazard_entry_t;

  // Legal configurations: 1..4 stages, load forwardable somewhere inside them.
  function automatic bit hz_params_legal(input int wb_stages, input int load_stage,
                                         input int addr_width);
    return (wb_stages >= 1) && (wb_stages <= 4) &&
           (load_stage >= 1) && (load_stage <= wb_stages) &&
           (addr_width >= 1) && (addr_width <= HZ_RD_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/miriscv_hazard_match.sv
// Priority search of one source register against the in-flight write table.
// The youngest matching stage (smallest index) wins.
module miriscv_hazard_match
  import miriscv_hazard_pkg::*;
#(
  parameter int WB_STAGES      = 2,
  parameter int LOAD_STAGE     = WB_STAGES,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int SW             = $clog2(WB_STAGES + 1)
) (
  input  hazard_entry_t [WB_STAGES-1:0] entries,
  input  logic                          re,
  input  logic [GPR_ADDR_WIDTH-1:0]     addr,
  output logic                          hit,
  output logic                          ready,
  output logic [SW-1:0]                 stage
);

  // Walk from oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    stage = '0;
    if (re && (addr != '0)) begin
      for (int k = WB_STAGES; k >= 1; k--) begin
        if (entries[k-1].valid && entries[k-1].we &&
            (entries[k-1].rd == HZ_RD_MAX_WIDTH'(addr))) begin
          hit   = 1'b1;
          ready = !entries[k-1].load || (k >= LOAD_STAGE);
          stage = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/miriscv_hazard_unit.sv
// Scoreboard and operand forwarding for the miriscv decode stage.
// Tracks in-flight register writes, selects forwarded operands and stalls
// decode on hazards forwarding cannot resolve (load-use, or any match when
// forwarding is disabled).
module miriscv_hazard_unit
  import miriscv_hazard_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int WB_STAGES      = 2,
  parameter int LOAD_STAGE     = WB_STAGES,
  parameter int FWD_EN         = 1,
  localparam int SW            = $clog2(WB_STAGES + 1)
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           d_valid_i,
  input  logic                           d_kill_i,
  input  logic [GPR_ADDR_WIDTH-1:0]      d_rs1_addr_i,
  input  logic [GPR_ADDR_WIDTH-1:0]      d_rs2_addr_i,
  input  logic                           d_rs1_re_i,
  input  logic                           d_rs2_re_i,
  input  logic [GPR_ADDR_WIDTH-1:0]      d_rd_addr_i,
  input  logic                           d_wb_we_i,
  input  logic                           d_load_i,
  input  logic [XLEN-1:0]                gpr_rs1_data_i,
  input  logic [XLEN-1:0]                gpr_rs2_data_i,
  input  logic [WB_STAGES-1:0][XLEN-1:0] stage_data_i,
  input  logic                           pipe_stall_i,
  output logic [XLEN-1:0]                rs1_data_o,
  output logic [XLEN-1:0]                rs2_data_o,
  output logic [SW-1:0]                  rs1_src_o,
  output logic [SW-1:0]                  rs2_src_o,
  output logic                           stall_o,
  output logic [31:0]                    hazard_cnt_o
);

  if (!hz_params_legal(WB_STAGES, LOAD_STAGE, GPR_ADDR_WIDTH)) begin : g_bad_params
    $error("miriscv_hazard_unit: illegal WB_STAGES/LOAD_STAGE/GPR_ADDR_WIDTH");
  end

  localparam bit FWD = (FWD_EN != 0);

  // entries_q[k-1] is pipeline stage k; index 0 is the stage right after decode.
  hazard_entry_t [WB_STAGES-1:0] entries_q;
  hazard_entry_t                 new_entry;

  logic          rs1_hit, rs1_ready, rs2_hit, rs2_ready;
  logic [SW-1:0] rs1_stage, rs2_stage;
  logic          rs1_fwd, rs2_fwd;
  logic          hazard, insert;

  miriscv_hazard_match #(
    .WB_STAGES     (WB_STAGES),
    .LOAD_STAGE    (LOAD_STAGE),
    .GPR_ADDR_WIDTH(GPR_ADDR_WIDTH),
    .SW            (SW)
  ) u_match_rs1 (
    .entries(entries_q),
    .re     (d_rs1_re_i),
    .addr   (d_rs1_addr_i),
    .hit    (rs1_hit),
    .ready  (rs1_ready),
    .stage  (rs1_stage)
  );

  miriscv_hazard_match #(
    .WB_STAGES     (WB_STAGES),
    .LOAD_STAGE    (LOAD_STAGE),
    .GPR_ADDR_WIDTH(GPR_ADDR_WIDTH),
    .SW            (SW)
  ) u_match_rs2 (
    .entries(entries_q),
    .re     (d_rs2_re_i),
    .addr   (d_rs2_addr_i),
    .hit    (rs2_hit),
    .ready  (rs2_ready),
    .stage  (rs2_stage)
  );

  assign rs1_fwd = rs1_hit && rs1_ready && FWD;
  assign rs2_fwd = rs2_hit && rs2_ready && FWD;

  // A kill suppresses the hazard so a dead instruction never stalls decode.
  assign hazard  = d_valid_i && !d_kill_i &&
                   ((rs1_hit && !rs1_fwd) || (rs2_hit && !rs2_fwd));
  assign stall_o = hazard || pipe_stall_i;
  assign insert  = d_valid_i && !d_kill_i && !hazard;

  // rs1 operand mux: GPR unless a ready producer is forwarded from its stage.
  always_comb begin
    rs1_data_o = gpr_rs1_data_i;
    rs1_src_o  = SW'(HZ_SRC_GPR);
    if (rs1_fwd) begin
      rs1_src_o = rs1_stage;
      for (int k = 0; k < WB_STAGES; k++) begin
        if (rs1_stage == SW'(k + 1)) rs1_data_o = stage_data_i[k];
      end
    end
  end

  // rs2 operand mux, resolved independently of rs1.
  always_comb begin
    rs2_data_o = gpr_rs2_data_i;
    rs2_src_o  = SW'(HZ_SRC_GPR);
    if (rs2_fwd) begin
      rs2_src_o = rs2_stage;
      for (int k = 0; k < WB_STAGES; k++) begin
        if (rs2_stage == SW'(k + 1)) rs2_data_o = stage_data_i[k];
      end
    end
  end

  // Decode entry; writes to x0 are recorded as non-writing so they never match.
  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.rd    = HZ_RD_MAX_WIDTH'(d_rd_addr_i);
    new_entry.we    = d_wb_we_i && (d_rd_addr_i != '0);
    new_entry.load  = d_load_i;
  end

  // Shift the table one stage per unstalled cycle, inserting the decode entry or a bubble.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      entries_q <= '0;
    end else if (!pipe_stall_i) begin
      for (int k = WB_STAGES - 1; k >= 1; k--) begin
        entries_q[k] <= entries_q[k-1];
      end
      entries_q[0] <= insert ? new_entry : '0;
    end
  end

  // Saturating count of cycles in which decode was held by a hazard.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hazard_cnt_o <= '0;
    end else if (hazard && (hazard_cnt_o != 32'hFFFF_FFFF)) begin
      hazard_cnt_o <= hazard_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_miriscv_hazard_unit.sv
// Bench for miriscv_hazard_unit: four configurations driven by shared decode
// inputs, directed scenarios plus a randomized run against a scoreboard that
// tracks each in-flight write by its age since insertion.
module tb_miriscv_hazard_unit;

  localparam int NI = 4;
  // Configurations: {WB_STAGES, LOAD_STAGE, FWD_EN}
  localparam int MW [NI] = '{2, 3, 2, 3};
  localparam int ML [NI] = '{2, 3, 2, 1};
  localparam int MF [NI] = '{1, 1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  logic        d_valid, d_kill, rs1_re, rs2_re, d_we, d_load, pstall;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [31:0] gpr1, gpr2;
  logic [31:0] sd [NI][4];

  logic [31:0] o_r1d [NI];
  logic [31:0] o_r2d [NI];
  logic [1:0]  o_r1s [NI];
  logic [1:0]  o_r2s [NI];
  logic        o_st  [NI];
  logic [31:0] o_cnt [NI];

  int checks = 0;
  int errors = 0;

  miriscv_hazard_unit #(.XLEN(32), .GPR_ADDR_WIDTH(5), .WB_STAGES(2), .LOAD_STAGE(2), .FWD_EN(1)) dut0 (
    .clk_i(clk), .arstn_i(arstn), .d_valid_i(d_valid), .d_kill_i(d_kill),
    .d_rs1_addr_i(rs1_a), .d_rs2_addr_i(rs2_a), .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
    .d_rd_addr_i(rd_a), .d_wb_we_i(d_we), .d_load_i(d_load),
    .gpr_rs1_data_i(gpr1), .gpr_rs2_data_i(gpr2),
    .stage_data_i({sd[0][1], sd[0][0]}), .pipe_stall_i(pstall),
    .rs1_data_o(o_r1d[0]), .rs2_data_o(o_r2d[0]), .rs1_src_o(o_r1s[0]), .rs2_src_o(o_r2s[0]),
    .stall_o(o_st[0]), .hazard_cnt_o(o_cnt[0]));

  miriscv_hazard_unit #(.XLEN(32), .GPR_ADDR_WIDTH(5), .WB_STAGES(3), .LOAD_STAGE(3), .FWD_EN(1)) dut1 (
    .clk_i(clk), .arstn_i(arstn), .d_valid_i(d_valid), .d_kill_i(d_kill),
    .d_rs1_addr_i(rs1_a), .d_rs2_addr_i(rs2_a), .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
    .d_rd_addr_i(rd_a), .d_wb_we_i(d_we), .d_load_i(d_load),
    .gpr_rs1_data_i(gpr1), .gpr_rs2_data_i(gpr2),
    .stage_data_i({sd[1][2], sd[1][1], sd[1][0]}), .pipe_stall_i(pstall),
    .rs1_data_o(o_r1d[1]), .rs2_data_o(o_r2d[1]), .rs1_src_o(o_r1s[1]), .rs2_src_o(o_r2s[1]),
    .stall_o(o_st[1]), .hazard_cnt_o(o_cnt[1]));

  miriscv_hazard_unit #(.XLEN(32), .GPR_ADDR_WIDTH(5), .WB_STAGES(2), .LOAD_STAGE(2), .FWD_EN(0)) dut2 (
    .clk_i(clk), .arstn_i(arstn), .d_valid_i(d_valid), .d_kill_i(d_kill),
    .d_rs1_addr_i(rs1_a), .d_rs2_addr_i(rs2_a), .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
    .d_rd_addr_i(rd_a), .d_wb_we_i(d_we), .d_load_i(d_load),
    .gpr_rs1_data_i(gpr1), .gpr_rs2_data_i(gpr2),
    .stage_data_i({sd[2][1], sd[2][0]}), .pipe_stall_i(pstall),
    .rs1_data_o(o_r1d[2]), .rs2_data_o(o_r2d[2]), .rs1_src_o(o_r1s[2]), .rs2_src_o(o_r2s[2]),
    .stall_o(o_st[2]), .hazard_cnt_o(o_cnt[2]));

  miriscv_hazard_unit #(.XLEN(32), .GPR_ADDR_WIDTH(5), .WB_STAGES(3), .LOAD_STAGE(1), .FWD_EN(1)) dut3 (
    .clk_i(clk), .arstn_i(arstn), .d_valid_i(d_valid), .d_kill_i(d_kill),
    .d_rs1_addr_i(rs1_a), .d_rs2_addr_i(rs2_a), .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
    .d_rd_addr_i(rd_a), .d_wb_we_i(d_we), .d_load_i(d_load),
    .gpr_rs1_data_i(gpr1), .gpr_rs2_data_i(gpr2),
    .stage_data_i({sd[3][2], sd[3][1], sd[3][0]}), .pipe_stall_i(pstall),
    .rs1_data_o(o_r1d[3]), .rs2_data_o(o_r2d[3]), .rs1_src_o(o_r1s[3]), .rs2_src_o(o_r2s[3]),
    .stall_o(o_st[3]), .hazard_cnt_o(o_cnt[3]));

  // ---------------- reference model: in-flight writes tagged with their age ----------------
  bit          mv   [NI][4];
  logic [4:0]  mrd  [NI][4];
  bit          mwe  [NI][4];
  bit          mld  [NI][4];
  int          mage [NI][4];
  logic [31:0] mcnt [NI];
  bit          mhz  [NI];

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mcnt[i] = 0;
      mhz[i]  = 0;
      for (int j = 0; j < 4; j++) begin
        mv[i][j] = 0; mrd[i][j] = 0; mwe[i][j] = 0; mld[i][j] = 0; mage[i][j] = 0;
      end
    end
  endtask

  function automatic void mlook(input int i, input bit re, input logic [4:0] a,
                                output bit hit, output bit rdy, output int st);
    int best = 100;
    hit = 0; rdy = 0; st = 0;
    if (re && a != 5'd0) begin
      for (int j = 0; j < 4; j++) begin
        if (mv[i][j] && mwe[i][j] && mrd[i][j] == a && mage[i][j] < best) begin
          best = mage[i][j];
          hit  = 1;
          rdy  = !mld[i][j] || (mage[i][j] >= ML[i]);
          st   = mage[i][j];
        end
      end
    end
  endfunction

  task automatic model_clock();
    for (int i = 0; i < NI; i++) begin
      if (!pstall) begin
        for (int j = 0; j < 4; j++) begin
          if (mv[i][j]) begin
            mage[i][j]++;
            if (mage[i][j] > MW[i]) mv[i][j] = 0;
          end
        end
        if (d_valid && !d_kill && !mhz[i]) begin
          for (int j = 0; j < 4; j++) begin
            if (!mv[i][j]) begin
              mv[i][j] = 1; mrd[i][j] = rd_a; mwe[i][j] = d_we && (rd_a != 0);
              mld[i][j] = d_load; mage[i][j] = 1;
              break;
            end
          end
        end
      end
      if (mhz[i] && mcnt[i] != 32'hFFFF_FFFF) mcnt[i]++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    d_valid = 0; d_kill = 0; rs1_re = 0; rs2_re = 0; d_we = 0; d_load = 0; pstall = 0;
    rs1_a = 0; rs2_a = 0; rd_a = 0; gpr1 = 0; gpr2 = 0;
    for (int i = 0; i < NI; i++) for (int j = 0; j < 4; j++) sd[i][j] = 0;
  endtask

  task automatic set_dec(input bit v, input logic [4:0] r1, input bit e1, input logic [4:0] r2,
                         input bit e2, input logic [4:0] rd, input bit we, input bit ld);
    d_valid = v; rs1_a = r1; rs1_re = e1; rs2_a = r2; rs2_re = e2; rd_a = rd; d_we = we; d_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    arstn = 0;
    @(negedge clk);
    @(negedge clk);
    arstn = 1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    arstn = 0;
    set_dec(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0);
    gpr1 = 32'hAAAA_0001; gpr2 = 32'hBBBB_0002; pstall = 1;
    #2;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_st[i] !== 1'b1 || o_r1s[i] !== 2'd0 || o_r2s[i] !== 2'd0 ||
          o_r1d[i] !== gpr1 || o_r2d[i] !== gpr2 || o_cnt[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset[%0d]: stall=%b src=%0d/%0d data=%h/%h cnt=%0d, want stall=1 src=0/0 data=%h/%h cnt=0",
                 i, o_st[i], o_r1s[i], o_r2s[i], o_r1d[i], o_r2d[i], o_cnt[i], gpr1, gpr2);
      end
    end
    pstall = 0;
    #1;
    checks++;
    if (o_st[0] !== 1'b0) begin
      errors++; $display("FAIL reset_nostall: stall=%b want 0", o_st[0]);
    end
    do_reset();
  endtask

  task automatic test_independent();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    set_dec(1, 5'd5, 1, 5'd6, 1, 5'd4, 1, 0);
    gpr1 = 32'h55; gpr2 = 32'h66;
    @(negedge clk);
    checks++;
    if (o_st[0] !== 0 || o_r1s[0] !== 0 || o_r2s[0] !== 0 || o_r1d[0] !== 32'h55 || o_r2d[0] !== 32'h66) begin
      errors++;
      $display("FAIL independent: stall=%b src=%0d/%0d data=%h/%h want 0 0/0 55/66",
               o_st[0], o_r1s[0], o_r2s[0], o_r1d[0], o_r2d[0]);
    end
    tick();
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick();
    set_dec(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0);
    sd[0][0] = 32'h1234; gpr1 = 32'hDEAD; gpr2 = 32'h0;
    @(negedge clk);
    checks++;
    if (o_st[0] !== 0 || o_r1s[0] !== 2'd1 || o_r1d[0] !== 32'h1234 || o_r2s[0] !== 0) begin
      errors++;
      $display("FAIL alu_b2b: stall=%b src1=%0d data1=%h src2=%0d want 0 1 1234 0",
               o_st[0], o_r1s[0], o_r1d[0], o_r2s[0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
    tick();
    set_dec(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
    sd[1][2] = 32'hCAFE; sd[0][1] = 32'hBEEF; sd[3][0] = 32'hF00D; gpr1 = 32'h1; gpr2 = 32'h2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (o_st[1] !== 1'b1) begin
        errors++; $display("FAIL load_use_stall c=%0d: stall=%b want 1", c, o_st[1]);
      end
      if (c == 0) begin
        checks++;
        if (o_st[3] !== 0 || o_r1s[3] !== 2'd1 || o_r1d[3] !== 32'hF00D) begin
          errors++;
          $display("FAIL load_stage1_fwd: stall=%b src=%0d data=%h want 0 1 f00d", o_st[3], o_r1s[3], o_r1d[3]);
        end
      end else begin
        checks++;
        if (o_st[0] !== 0 || o_r1s[0] !== 2'd2 || o_r2d[0] !== 32'hBEEF) begin
          errors++;
          $display("FAIL load_wb2_fwd: stall=%b src=%0d data=%h want 0 2 beef", o_st[0], o_r1s[0], o_r2d[0]);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (o_st[1] !== 0 || o_r1s[1] !== 2'd3 || o_r2s[1] !== 2'd3 ||
        o_r1d[1] !== 32'hCAFE || o_r2d[1] !== 32'hCAFE || o_cnt[1] !== 32'd2) begin
      errors++;
      $display("FAIL load_use_fwd: stall=%b src=%0d/%0d data=%h/%h cnt=%0d want 0 3/3 cafe/cafe 2",
               o_st[1], o_r1s[1], o_r2s[1], o_r1d[1], o_r2d[1], o_cnt[1]);
    end
    tick();
  endtask

  task automatic test_youngest_wins();
    do_reset();
    set_dec(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 0);
    tick();
    tick();
    set_dec(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, 0);
    sd[0][0] = 32'd2; sd[0][1] = 32'd1;
    @(negedge clk);
    checks++;
    if (o_st[0] !== 0 || o_r1s[0] !== 2'd1 || o_r1d[0] !== 32'd2 || o_r2s[0] !== 0) begin
      errors++;
      $display("FAIL youngest: stall=%b src=%0d data=%h src2=%0d want 0 1 2 0", o_st[0], o_r1s[0], o_r1d[0], o_r2s[0]);
    end
    tick();
    set_dec(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1);
    tick();
    set_dec(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0);
    gpr1 = 32'h77; gpr2 = 32'h88;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_st[i] !== 0 || o_r1s[i] !== 0 || o_r2s[i] !== 0 || o_r1d[i] !== 32'h77) begin
        errors++;
        $display("FAIL x0[%0d]: stall=%b src=%0d/%0d data=%h want 0 0/0 77", i, o_st[i], o_r1s[i], o_r2s[i], o_r1d[i]);
      end
    end
    tick();
  endtask

  task automatic test_pipe_stall();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
    tick();
    set_dec(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    sd[1][2] = 32'h5A5A;
    pstall = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (o_st[1] !== 1'b1 || o_cnt[1] !== 32'(c)) begin
        errors++; $display("FAIL pstall c=%0d: stall=%b cnt=%0d want 1 %0d", c, o_st[1], o_cnt[1], c);
      end
      tick();
    end
    pstall = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (o_st[1] !== 1'b1 || o_cnt[1] !== 32'(3 + c)) begin
        errors++; $display("FAIL pstall_release c=%0d: stall=%b cnt=%0d want 1 %0d", c, o_st[1], o_cnt[1], 3 + c);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (o_st[1] !== 0 || o_r1s[1] !== 2'd3 || o_r1d[1] !== 32'h5A5A || o_cnt[1] !== 32'd5) begin
      errors++;
      $display("FAIL pstall_resume: stall=%b src=%0d data=%h cnt=%0d want 0 3 5a5a 5", o_st[1], o_r1s[1], o_r1d[1], o_cnt[1]);
    end
    tick();
  endtask

  task automatic test_kill();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
    tick();
    set_dec(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    d_kill = 1;
    @(negedge clk);
    checks++;
    if (o_st[1] !== 0) begin
      errors++; $display("FAIL kill_stall: stall=%b want 0", o_st[1]);
    end
    tick();
    d_kill = 0;
    set_dec(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0);
    gpr1 = 32'h99;
    @(negedge clk);
    checks++;
    if (o_st[1] !== 0 || o_r1s[1] !== 0 || o_r1d[1] !== 32'h99 || o_cnt[1] !== 0) begin
      errors++;
      $display("FAIL kill_noinsert: stall=%b src=%0d data=%h cnt=%0d want 0 0 99 0", o_st[1], o_r1s[1], o_r1d[1], o_cnt[1]);
    end
    tick();
  endtask

  task automatic test_no_forward();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0);
    tick();
    set_dec(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    gpr1 = 32'h4242; sd[2][0] = 32'h1111; sd[2][1] = 32'h2222;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (o_st[2] !== 1'b1) begin
        errors++; $display("FAIL nofwd_stall c=%0d: stall=%b want 1", c, o_st[2]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (o_st[2] !== 0 || o_r1s[2] !== 0 || o_r1d[2] !== 32'h4242 || o_cnt[2] !== 32'd2) begin
      errors++;
      $display("FAIL nofwd_release: stall=%b src=%0d data=%h cnt=%0d want 0 0 4242 2", o_st[2], o_r1s[2], o_r1d[2], o_cnt[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_dec(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0);
    tick();
    set_dec(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    @(negedge clk);
    checks++;
    if (o_st[2] !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: stall=%b want 1", o_st[2]);
    end
    #1 arstn = 0;
    #1;
    checks++;
    if (o_st[2] !== 0 || o_cnt[2] !== 0) begin
      errors++; $display("FAIL midrst_async: stall=%b cnt=%0d want 0 0", o_st[2], o_cnt[2]);
    end
    #1 arstn = 1;
    tick();
    @(negedge clk);
    checks++;
    if (o_st[2] !== 0 || o_r1s[2] !== 0) begin
      errors++; $display("FAIL midrst_after: stall=%b src=%0d want 0 0", o_st[2], o_r1s[2]);
    end
    tick();
  endtask

  task automatic test_random();
    bit h1, y1, h2, y2, f1, f2, hz;
    int s1, s2;
    logic [31:0] ed1, ed2;
    do_reset();
    model_clear();
    for (int n = 0; n < 400; n++) begin
      d_valid = ($urandom_range(0, 3) != 0);
      d_kill  = ($urandom_range(0, 9) == 0);
      pstall  = ($urandom_range(0, 6) == 0);
      rs1_a = 5'($urandom_range(0, 6)); rs1_re = ($urandom_range(0, 3) != 0);
      rs2_a = 5'($urandom_range(0, 6)); rs2_re = ($urandom_range(0, 3) != 0);
      rd_a  = 5'($urandom_range(0, 6)); d_we   = ($urandom_range(0, 3) != 0);
      d_load = ($urandom_range(0, 2) == 0);
      gpr1 = $urandom; gpr2 = $urandom;
      for (int i = 0; i < NI; i++) for (int j = 0; j < 4; j++) sd[i][j] = $urandom;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        mlook(i, rs1_re, rs1_a, h1, y1, s1);
        mlook(i, rs2_re, rs2_a, h2, y2, s2);
        f1 = h1 && y1 && (MF[i] != 0);
        f2 = h2 && y2 && (MF[i] != 0);
        hz = d_valid && !d_kill && ((h1 && !f1) || (h2 && !f2));
        mhz[i] = hz;
        ed1 = f1 ? sd[i][s1-1] : gpr1;
        ed2 = f2 ? sd[i][s2-1] : gpr2;
        checks++;
        if (o_st[i] !== (hz || pstall) || o_cnt[i] !== mcnt[i]) begin
          errors++;
          $display("FAIL rnd_stall[%0d] n=%0d: stall=%b cnt=%0d want %b %0d", i, n, o_st[i], o_cnt[i], hz || pstall, mcnt[i]);
        end
        if (!(h1 && !f1)) begin
          checks++;
          if (o_r1s[i] !== 2'(f1 ? s1 : 0) || o_r1d[i] !== ed1) begin
            errors++;
            $display("FAIL rnd_rs1[%0d] n=%0d: src=%0d data=%h want %0d %h", i, n, o_r1s[i], o_r1d[i], f1 ? s1 : 0, ed1);
          end
        end
        if (!(h2 && !f2)) begin
          checks++;
          if (o_r2s[i] !== 2'(f2 ? s2 : 0) || o_r2d[i] !== ed2) begin
            errors++;
            $display("FAIL rnd_rs2[%0d] n=%0d: src=%0d data=%h want %0d %h", i, n, o_r2s[i], o_r2d[i], f2 ? s2 : 0, ed2);
          end
        end
      end
      @(posedge clk);
      model_clock();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_alu_back_to_back();
    test_load_use();
    test_youngest_wins();
    test_pipe_stall();
    test_kill();
    test_no_forward();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miriscv_hazard_unit.md
# miriscv_hazard_unit

Scoreboard and operand-forwarding unit for the pipelined miriscv core. It tracks every in-flight register write between decode and writeback over `WB_STAGES` pipeline stages. For each decode-stage source operand it selects either the GPR read value or a forwarded stage result, and stalls decode on read-after-write hazards that forwarding cannot cover, such as load-use. It sits beside the decode stage and drives the decode stall/bubble control.

## Interface
Parameters:
- `XLEN`, 32, data width
- `GPR_ADDR_WIDTH`, 5, register address width
- `WB_STAGES`, 2, stages after decode up to and including writeback, legal 1..4
- `LOAD_STAGE`, `WB_STAGES`, first stage (1-based) at which a load result is forwardable, legal 1..`WB_STAGES`
- `FWD_EN`, 1, 0 disables forwarding: any match stalls until the entry retires

Ports (`SW` = `$clog2(WB_STAGES+1)`):
- `clk_i`  in  1  clock
- `arstn_i`  in  1  reset, asynchronous, active-low
- `d_valid_i`  in  1  valid instruction in decode
- `d_kill_i`  in  1  decode instruction is killed; it is not inserted
- `d_rs1_addr_i`, `d_rs2_addr_i`  in  `GPR_ADDR_WIDTH`  source addresses
- `d_rs1_re_i`, `d_rs2_re_i`  in  1  source read enables
- `d_rd_addr_i`  in  `GPR_ADDR_WIDTH`  destination
- `d_wb_we_i`  in  1  instruction writes `rd`
- `d_load_i`  in  1  instruction is a load
- `gpr_rs1_data_i`, `gpr_rs2_data_i`  in  `XLEN`  register file read data
- `stage_data_i`  in  `[WB_STAGES][XLEN]`  result currently held in stage k (index k-1)
- `pipe_stall_i`  in  1  downstream stall (LSU/MDU); the whole table holds
- `rs1_data_o`, `rs2_data_o`  out  `XLEN`  resolved operands
- `rs1_src_o`, `rs2_src_o`  out  `SW`  0 = GPR, k = forwarded from stage k
- `stall_o`  out  1  decode must hold
- `hazard_cnt_o`  out  32  saturating count of hazard-stall cycles

## Operation
- The table holds entries `stage[1..WB_STAGES]`. Each entry is {valid, rd, we, load}. Stage 1 is the stage directly after decode. Stage `WB_STAGES` writes the GPR at the end of its cycle, so its data is forwarded because the GPR still returns the old value.
- Entry ready rule:
  - Non-load: ready in every stage.
  - Load: ready only when k ≥ `LOAD_STAGE`.
- Source lookup runs per source (rs1, rs2) and is active only when `re`=1 and addr≠0:
  - Match: valid & we & rd==addr. The youngest match (smallest k) wins.
  - No match: GPR data, src=0.
  - Match, ready and `FWD_EN`=1: `stage_data_i[k-1]`, src=k.
  - Otherwise: raise the hazard.
- `hazard` = `d_valid_i` & ~`d_kill_i` & (rs1 hazard | rs2 hazard).
- `stall_o` = `hazard` | `pipe_stall_i`.
- Entries with rd=0 are stored with we=0.
- Table update at posedge:
  - `pipe_stall_i`=1: all entries hold, no insertion.
  - Otherwise: `stage[k]` ← `stage[k-1]`, and the entry from `stage[WB_STAGES]` retires.
  - `stage[1]` ← the decode entry if `d_valid_i` & ~`d_kill_i` & ~`hazard`. Otherwise `stage[1]` ← bubble (valid=0).
- Kill while hazarded: the kill wins. No stall, no insertion.
- `hazard_cnt_o` increments on every cycle with `hazard`=1 and saturates at 0xFFFF_FFFF.

## Timing
- Lookup, the `stall_o` path and the operand muxes are purely combinational from decode and stage inputs. Zero-cycle latency.
- Load-use with `LOAD_STAGE`=L: the dependent instruction stalls L−1 cycles, then forwards from stage L. It stalls 0 cycles if L=1.
- With `FWD_EN`=0, a dependent instruction stalls until the producer retires. It reads the GPR in the cycle after the producer leaves stage `WB_STAGES`.
- Reset (asynchronous):
  - All entries valid=0 and `hazard_cnt_o`=0.
  - Combinational outputs consequently equal: `rsX_data_o`=GPR data, `rsX_src_o`=0, `stall_o`=`pipe_stall_i`.
- Reset deasserted mid-stall: no entry survives, and the first cycle after reset issues freely.
- rs1==rs2 are resolved independently and give identical selection.
- Simultaneous hazard and `pipe_stall_i`: the table holds; it does not bubble-shift.

## Structure
- `miriscv_hazard_pkg` contains:
  - `hazard_entry_t` packed struct {valid, rd, we, load}.
  - `HZ_SRC_GPR` constant = 0.
  - Parameter-legality checks as elaboration assertions.
- Sub-module `miriscv_hazard_match`: a combinational priority search of one source against the table. It outputs hit, ready and stage index, and is instantiated twice.
- The top holds the table registers, shift/insert logic, operand muxes and counter.

## Test plan
- Independent ops: ADD x3 then ADD x4,x5,x6 → `stall_o`=0, `rs1_src_o`=0, operands = GPR data.
- ALU back-to-back (`WB_STAGES`=2): ADD x5 (result 0x1234) then ADD x6,x5,x0 → `rs1_src_o`=1, `rs1_data_o`=0x1234, no stall.
- Load-use (`WB_STAGES`=3, `LOAD_STAGE`=3): LW x7 then ADD x8,x7,x7 → 2 stall cycles with bubbles in stage 1, then src=3 on both operands; `hazard_cnt_o`=2.
- Youngest-wins: ADDI x9=1, ADDI x9=2, ADD x10,x9 → forwards 2 from stage 1. Also check x0 as rd and as rs: never hazards, src=0.
- `pipe_stall_i` held 3 cycles with a pending load-use → table frozen, no counter increment beyond hazard cycles; on release normal sequence resumes. Also check `d_kill_i` during a hazard → `stall_o`=0, no insertion.
- `FWD_EN`=0: dependent on ADD in stage 1 → stalls `WB_STAGES` cycles, then src=0. Also check `arstn_i` pulse mid-stall → table cleared, `stall_o`=0 next cycle.
